sha3_sponge_ctrl: RTL

- Sponge-mode initiator for the Keccak-f[1600] permutation core (`sha3_f_func`).
- Accepts a byte-oriented message as a stream of 64-bit words, XOR-absorbs it into a local 1600-bit state, and applies pad10*1 with a domain byte.
- Drives the core's level-start/level-end handshake once per rate block, then squeezes digest words onto a valid/ready output stream.
- Sits between the Picnic hashing front-end and the permutation core. The default configuration computes SHA3-256.

---
 rtl/sha3_sponge_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: sponge-mode initiator for the Keccak-f[1600] core.
// Takes the message as 64-bit words and XOR-absorbs it into a local
// 1600-bit state. It then applies pad10*1 with the DOMAIN byte, runs one
// core permutation per rate block, and squeezes OUT_WORDS digest words out.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   msg_valid/ready   message word handshake (msg_ready registered)
//   msg_data          8 message bytes, first byte in [63:56]
//   msg_last          final message word
//   msg_nbytes        valid bytes in the final word (values >8 clamp to 8)
//   f_start / f_end   level handshake to the permutation core
//   f_state_out       state presented to the core, byte k at [8k+7:8k]
//   f_state_in        permuted state returned by the core, same layout
//   out_valid/ready   digest word handshake (out_valid registered)
//   out_data          digest bytes 8i..8i+7, byte 8i in [63:56]
//   out_last          marks digest word OUT_WORDS-1
module sha3_sponge_ctrl #(
   parameter int unsigned RATE_WORDS = 17,
   parameter logic [7:0]  DOMAIN     = 8'h06,
   parameter int unsigned OUT_WORDS  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          msg_valid,
   output logic          msg_ready,
   input  logic [63:0]   msg_data,
   input  logic          msg_last,
   input  logic [3:0]    msg_nbytes,
   output logic          f_start,
   input  logic          f_end,
   output logic [1599:0] f_state_out,
   input  logic [1599:0] f_state_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   out_data,
   output logic          out_last
);

   localparam int unsigned STATE_W    = 1600;
   localparam int unsigned LANE_W     = 64;
   localparam int unsigned RATE_BYTES = 8 * RATE_WORDS;
   localparam int unsigned WIDX_W     = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
   localparam int unsigned POS_W      = $clog2(RATE_BYTES + 1);
   localparam int unsigned SQ_W       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABSORB,
      S_PAD,
      S_PERM,
      S_GAP,
      S_SQUEEZE
   } state_e;

   state_e               state_q, state_d;
   state_e               ret_q, ret_d;
   logic [STATE_W-1:0]   st_q, st_d;
   logic [WIDX_W-1:0]    widx_q, widx_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic [SQ_W-1:0]      sq_cnt_q, sq_cnt_d;
   logic [WIDX_W-1:0]    sq_idx_q, sq_idx_d;
   logic                 msg_ready_q, msg_ready_d;
   logic                 f_start_q, f_start_d;
   logic                 out_valid_q, out_valid_d;
   logic [63:0]          out_data_q, out_data_d;
   logic                 out_last_q, out_last_d;

   logic [3:0]           nb_c;
   logic [LANE_W-1:0]    msg_lane_c;
   logic [POS_W-1:0]     pad_pos_c;
   logic [LANE_W-1:0]    out_lane_c;

   // Incoming word as a little-endian lane; bytes past msg_nbytes of the last word are dropped
   always_comb begin
      nb_c       = (msg_nbytes > 4'd8) ? 4'd8 : msg_nbytes;
      msg_lane_c = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         if (!msg_last || (4'(j) < nb_c)) begin
            msg_lane_c[8*j +: 8] = msg_data[8*(7-j) +: 8];
         end
      end
      pad_pos_c = POS_W'({widx_q, 3'b000}) + POS_W'(nb_c);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      st_d        = st_q;
      widx_d      = widx_q;
      pos_d       = pos_q;
      sq_cnt_d    = sq_cnt_q;
      sq_idx_d    = sq_idx_q;
      msg_ready_d = 1'b0;
      f_start_d   = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      out_lane_c  = '0;

      case (state_q)
         S_IDLE: begin
            st_d     = '0;
            widx_d   = '0;
            sq_cnt_d = '0;
            sq_idx_d = '0;
            state_d  = S_ABSORB;
         end

         S_ABSORB: begin
            if (msg_valid && msg_ready_q) begin
               for (int unsigned lane = 0; lane < RATE_WORDS; lane++) begin
                  if (widx_q == WIDX_W'(lane)) begin
                     st_d[LANE_W*lane +: LANE_W] = st_q[LANE_W*lane +: LANE_W] ^ msg_lane_c;
                  end
               end
               if (msg_last) begin
                  // A message ending exactly on a block boundary pads a fresh block
                  if (pad_pos_c == POS_W'(RATE_BYTES)) begin
                     pos_d   = '0;
                     ret_d   = S_PAD;
                     state_d = S_PERM;
                  end else begin
                     pos_d   = pad_pos_c;
                     state_d = S_PAD;
                  end
               end else if (widx_q == WIDX_W'(RATE_WORDS - 1)) begin
                  widx_d  = '0;
                  ret_d   = S_ABSORB;
                  state_d = S_PERM;
               end else begin
                  widx_d = widx_q + WIDX_W'(1);
               end
            end
         end

         S_PAD: begin
            // Domain byte at the pad position, 0x80 on the last rate byte (may coincide)
            for (int unsigned k = 0; k < RATE_BYTES; k++) begin
               if (pos_q == POS_W'(k)) begin
                  st_d[8*k +: 8] = st_q[8*k +: 8] ^ DOMAIN;
               end
            end
            st_d[8*(RATE_BYTES-1) +: 8] = st_d[8*(RATE_BYTES-1) +: 8] ^ 8'h80;
            ret_d   = S_SQUEEZE;
            state_d = S_PERM;
         end

         S_PERM: begin
            if (f_end) begin
               st_d    = f_state_in;
               state_d = S_GAP;
            end
         end

         // One cycle with f_start low lets the core drop f_end before the next use
         S_GAP: begin
            state_d = ret_q;
         end

         S_SQUEEZE: begin
            if (out_valid_q && out_ready) begin
               if (sq_cnt_q == SQ_W'(OUT_WORDS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  sq_cnt_d = sq_cnt_q + SQ_W'(1);
                  if (sq_idx_q == WIDX_W'(RATE_WORDS - 1)) begin
                     sq_idx_d = '0;
                     ret_d    = S_SQUEEZE;
                     state_d  = S_PERM;
                  end else begin
                     sq_idx_d = sq_idx_q + WIDX_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the next state so each strobe aligns exactly with its state
      msg_ready_d = (state_d == S_ABSORB);
      f_start_d   = (state_d == S_PERM);
      out_valid_d = (state_d == S_SQUEEZE);

      // st_q already holds the squeezed block whenever SQUEEZE is entered or held
      for (int unsigned lane = 0; lane < RATE_WORDS; lane++) begin
         if (sq_idx_d == WIDX_W'(lane)) begin
            out_lane_c = st_q[LANE_W*lane +: LANE_W];
         end
      end
      for (int unsigned j = 0; j < 8; j++) begin
         out_data_d[8*(7-j) +: 8] = out_lane_c[8*j +: 8];
      end
      out_last_d = (state_d == S_SQUEEZE) && (sq_cnt_d == SQ_W'(OUT_WORDS - 1));
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ret_q       <= S_ABSORB;
         st_q        <= '0;
         widx_q      <= '0;
         pos_q       <= '0;
         sq_cnt_q    <= '0;
         sq_idx_q    <= '0;
         msg_ready_q <= 1'b0;
         f_start_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         st_q        <= st_d;
         widx_q      <= widx_d;
         pos_q       <= pos_d;
         sq_cnt_q    <= sq_cnt_d;
         sq_idx_q    <= sq_idx_d;
         msg_ready_q <= msg_ready_d;
         f_start_q   <= f_start_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign msg_ready   = msg_ready_q;
   assign f_start     = f_start_q;
   assign f_state_out = st_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;

endmodule
